// File: rtl/test_monitor.sv
// test_monitor: riscv-tests completion checker snooping regfile writeback.
// Define TEST_MON_HALT_EN to hold halt high from done until next start.
module test_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_HARTS      = 1,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TESTNUM_REG    = 3,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_HARTS-1:0]      wb_we,
  input  logic [NUM_HARTS*5-1:0]    wb_waddr,
  input  logic [NUM_HARTS*XLEN-1:0] wb_wdata,
  output logic                      running,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [HW-1:0]             fail_hart,
  output logic [XLEN-1:0]           fail_testnum,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic                      halt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO
  } state_t;

  localparam logic [4:0] TN_A = 5'(TESTNUM_REG);
  localparam logic [4:0] DN_A = 5'(DONE_REG);
  localparam logic [4:0] PS_A = 5'(PASS_REG);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;

  logic [XLEN-1:0]      tnum  [NUM_HARTS];
  logic [XLEN-1:0]      pflag [NUM_HARTS];
  logic [NUM_HARTS-1:0] hdone;
  logic [NUM_HARTS-1:0] hok;
  logic [CNT_W-1:0]     cnt;

  logic            clr;
  logic            any_fail;
  logic            all_pass;
  logic            tmo_hit;
  logic [HW-1:0]   fh;
  logic [XLEN-1:0] ftn;

  assign clr      = start && (state != S_RUN);
  assign all_pass = &(hdone & hok);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign cycle_cnt = cnt;

  // descending scan so the lowest failing hart is reported
  always_comb begin
    any_fail = 1'b0;
    fh       = '0;
    ftn      = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (hdone[h] && !hok[h]) begin
        any_fail = 1'b1;
        fh       = HW'(h);
        ftn      = tnum[h];
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RUN: begin
        if (any_fail)      state_n = S_FAIL;
        else if (all_pass) state_n = S_PASS;
        else if (tmo_hit)  state_n = S_TMO;
      end
      default: begin
        if (start) state_n = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_hart    <= '0;
      fail_testnum <= '0;
    end else begin
      state   <= state_n;
      running <= (state_n == S_RUN);
      done    <= state_n inside {S_PASS, S_FAIL, S_TMO};
      pass    <= (state_n == S_PASS);
      fail    <= state_n inside {S_FAIL, S_TMO};
      timeout <= (state_n == S_TMO);
      if (clr) begin
        fail_hart    <= '0;
        fail_testnum <= '0;
      end else if (state == S_RUN && state_n == S_FAIL) begin
        fail_hart    <= fh;
        fail_testnum <= ftn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (state == S_RUN && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // shadows freeze once a hart reports done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdone <= '0;
      hok   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        tnum[h]  <= '0;
        pflag[h] <= '0;
      end
    end else if (clr) begin
      hdone <= '0;
      hok   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        tnum[h]  <= '0;
        pflag[h] <= '0;
      end
    end else if (state == S_RUN) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wb_we[h] && !hdone[h] &&
            wb_waddr[5*h +: 5] != 5'd0) begin
          if (wb_waddr[5*h +: 5] == TN_A)
            tnum[h] <= wb_wdata[XLEN*h +: XLEN];
          if (wb_waddr[5*h +: 5] == PS_A)
            pflag[h] <= wb_wdata[XLEN*h +: XLEN];
          if (wb_waddr[5*h +: 5] == DN_A &&
              wb_wdata[XLEN*h +: XLEN] == ONE) begin
            hdone[h] <= 1'b1;
            hok[h]   <= (pflag[h] == ONE);
          end
        end
      end
    end
  end

`ifdef TEST_MON_HALT_EN
  assign halt = done;
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: randomized and directed checks of test_monitor
// against a schedule-level reference model.
module tb_test_monitor;

  localparam int H  = 2;
  localparam int T  = 100;
  localparam int L  = 110;
  localparam int CW = 16;

`ifdef TEST_MON_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [H-1:0]    we = '0;
  logic [H*5-1:0]  wa = '0;
  logic [H*32-1:0] wd = '0;
  logic running, done, pass, fail, timeout, halt;
  logic [0:0]    fail_hart;
  logic [31:0]   fail_testnum;
  logic [CW-1:0] cycle_cnt;

  logic start1 = 1'b0;
  logic [0:0]  we1 = '0;
  logic [4:0]  wa1 = '0;
  logic [31:0] wd1 = '0;
  logic running1, done1, pass1, fail1, timeout1, halt1;
  logic [0:0]  fail_hart1;
  logic [31:0] fail_testnum1;
  logic [3:0]  cycle_cnt1;

  always #5 clk = ~clk;

  test_monitor #(
    .XLEN(32), .NUM_HARTS(H), .CNT_W(CW), .TIMEOUT_CYCLES(T)
  ) u0 (
    .clk(clk), .rst(rst), .start(start),
    .wb_we(we), .wb_waddr(wa), .wb_wdata(wd),
    .running(running), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_hart(fail_hart),
    .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt),
    .halt(halt)
  );

  test_monitor #(
    .XLEN(32), .NUM_HARTS(1), .CNT_W(4), .TIMEOUT_CYCLES(0)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .wb_we(we1), .wb_waddr(wa1), .wb_wdata(wd1),
    .running(running1), .done(done1), .pass(pass1),
    .fail(fail1), .timeout(timeout1), .fail_hart(fail_hart1),
    .fail_testnum(fail_testnum1), .cycle_cnt(cycle_cnt1),
    .halt(halt1)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit          sw [H][L+1];
  logic [4:0]  sa [H][L+1];
  logic [31:0] sd [H][L+1];

  bit          e_pass, e_fail, e_to;
  int          e_fh, e_end;
  logic [31:0] e_tn;

  task automatic clear_sched();
    for (int h = 0; h < H; h++)
      for (int c = 0; c <= L; c++) begin
        sw[h][c] = 1'b0;
        sa[h][c] = '0;
        sd[h][c] = '0;
      end
  endtask

  task automatic add(input int h, input int c,
                     input int a, input int d);
    sw[h][c] = 1'b1;
    sa[h][c] = 5'(a);
    sd[h][c] = 32'(d);
  endtask

  // per hart: first x26=1 write ends it; x3/x27 are the last
  // writes before that; the run ends one edge after the deciding hart
  task automatic model();
    int dc [H];
    bit ok [H];
    logic [31:0] tn [H];
    logic [31:0] pv [H];
    int ffirst;
    int last;
    bit all;
    int dec;
    ffirst = -1;
    last = 0;
    all = 1'b1;
    for (int h = 0; h < H; h++) begin
      dc[h] = -1;
      ok[h] = 1'b0;
      tn[h] = '0;
      pv[h] = '0;
      for (int c = 1; c <= L; c++)
        if (dc[h] < 0 && sw[h][c] && sa[h][c] != 0) begin
          if (sa[h][c] == 3)  tn[h] = sd[h][c];
          if (sa[h][c] == 27) pv[h] = sd[h][c];
          if (sa[h][c] == 26 && sd[h][c] == 1) begin
            dc[h] = c;
            ok[h] = (pv[h] == 1);
          end
        end
      if (dc[h] < 0) all = 1'b0;
      else if (!ok[h] && (ffirst < 0 || dc[h] < ffirst))
        ffirst = dc[h];
      if (dc[h] > last) last = dc[h];
    end
    e_fh = 0;
    e_tn = '0;
    e_pass = 1'b0;
    e_fail = 1'b0;
    e_to = 1'b0;
    if (ffirst >= 0) begin
      dec = ffirst + 1;
      for (int h = H - 1; h >= 0; h--)
        if (dc[h] == ffirst && !ok[h]) begin
          e_fh = h;
          e_tn = tn[h];
        end
    end else if (all) dec = last + 1;
    else dec = L + 100;
    if (dec <= T) begin
      e_end = dec;
      e_fail = (ffirst >= 0);
      e_pass = !e_fail;
    end else begin
      e_end = T;
      e_to = 1'b1;
      e_fh = 0;
      e_tn = '0;
    end
  endtask

  task automatic run_sched(input string nm, input bit rs);
    int rise;
    int rc;
    logic [4:0] st;
    logic [4:0] est;
    rise = -1;
    model();
    rc = rs ? $urandom_range(1, e_end) : 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      start = (c == rc);
      if (done && rise < 0) rise = c - 1;
      if (c == 1) begin
        n_chk++;
        if (running !== 1'b1 || cycle_cnt !== '0) begin
          n_fail++;
          $display("FAIL %s run_entry: running=%b cnt=%0d want 1/0",
                   nm, running, cycle_cnt);
        end
      end
      for (int h = 0; h < H; h++) begin
        we[h] = sw[h][c];
        wa[5*h +: 5] = sa[h][c];
        wd[32*h +: 32] = sd[h][c];
      end
    end
    @(negedge clk);
    start = 1'b0;
    we = '0;
    wa = '0;
    wd = '0;
    if (done && rise < 0) rise = L;
    st = {running, done, pass, fail, timeout};
    est = {1'b0, 1'b1, e_pass, e_fail | e_to, e_to};
    n_chk++;
    if (rise !== e_end) begin
      n_fail++;
      $display("FAIL %s done_edge: got %0d want %0d",
               nm, rise, e_end);
    end
    n_chk++;
    if (st !== est) begin
      n_fail++;
      $display("FAIL %s status: got %b want %b", nm, st, est);
    end
    n_chk++;
    if (fail_hart !== 1'(e_fh)) begin
      n_fail++;
      $display("FAIL %s fail_hart: got %0d want %0d",
               nm, fail_hart, e_fh);
    end
    if (e_fail) begin
      n_chk++;
      if (fail_testnum !== e_tn) begin
        n_fail++;
        $display("FAIL %s fail_testnum: got %0d want %0d",
                 nm, fail_testnum, e_tn);
      end
    end
    n_chk++;
    if (cycle_cnt !== CW'(e_end)) begin
      n_fail++;
      $display("FAIL %s cycle_cnt: got %0d want %0d",
               nm, cycle_cnt, e_end);
    end
    n_chk++;
    if (halt !== (HALT_EN & done)) begin
      n_fail++;
      $display("FAIL %s halt: got %b want %b",
               nm, halt, HALT_EN & done);
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({running, done, pass, fail, timeout, halt} !== '0 ||
        cycle_cnt !== '0 || fail_testnum !== '0) begin
      n_fail++;
      $display("FAIL reset_u0: status=%b cnt=%0d want 0",
               {running, done, pass, fail, timeout, halt}, cycle_cnt);
    end
    n_chk++;
    if ({running1, done1, pass1, fail1, timeout1} !== '0 ||
        cycle_cnt1 !== '0) begin
      n_fail++;
      $display("FAIL reset_u1: status=%b cnt=%0d want 0",
               {running1, done1, pass1, fail1, timeout1}, cycle_cnt1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we = '1;
      wa = (i < 2) ? {5'd27, 5'd27} : {5'd26, 5'd26};
      wd = {32'd1, 32'd1};
    end
    @(negedge clk);
    we = '0;
    @(negedge clk);
    n_chk++;
    if ({running, done, pass, fail, timeout} !== '0 ||
        cycle_cnt !== '0) begin
      n_fail++;
      $display("FAIL idle_ignore: status=%b cnt=%0d want 0",
               {running, done, pass, fail, timeout}, cycle_cnt);
    end
  endtask

  task automatic test_pass_two();
    clear_sched();
    add(0, 2, 3, 5);
    add(0, 5, 27, 1);
    add(0, 10, 26, 1);
    add(1, 15, 27, 1);
    add(1, 20, 26, 1);
    add(0, 12, 0, 1);
    run_sched("pass_two", 1'b0);
    n_chk++;
    if (pass !== 1'b1 || cycle_cnt !== CW'(21)) begin
      n_fail++;
      $display("FAIL pass_two_direct: pass=%b cnt=%0d want 1/21",
               pass, cycle_cnt);
    end
  endtask

  task automatic test_fail_hart1();
    clear_sched();
    add(0, 3, 27, 1);
    add(0, 10, 26, 1);
    add(1, 3, 3, 9);
    add(1, 4, 27, 0);
    add(1, 20, 26, 1);
    add(1, 25, 3, 44);
    run_sched("fail_hart1", 1'b0);
    n_chk++;
    if (fail !== 1'b1 || fail_hart !== 1'b1 ||
        fail_testnum !== 32'd9 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_hart1_direct: f=%b h=%0d tn=%0d to=%b want 1/1/9/0",
               fail, fail_hart, fail_testnum, timeout);
    end
  endtask

  task automatic test_fail_priority();
    clear_sched();
    add(0, 2, 3, 11);
    add(1, 2, 3, 22);
    add(0, 8, 26, 1);
    add(1, 8, 26, 1);
    run_sched("fail_priority", 1'b0);
  endtask

  task automatic test_timeout();
    clear_sched();
    add(0, 4, 27, 1);
    add(1, 30, 26, 2);
    run_sched("timeout", 1'b0);
    n_chk++;
    if (timeout !== 1'b1 || fail !== 1'b1 ||
        cycle_cnt !== CW'(T)) begin
      n_fail++;
      $display("FAIL timeout_direct: to=%b f=%b cnt=%0d want 1/1/%0d",
               timeout, fail, cycle_cnt, T);
    end
  endtask

  task automatic test_boundary();
    clear_sched();
    for (int h = 0; h < H; h++) begin
      add(h, 50, 27, 1);
      add(h, T - 1, 26, 1);
    end
    run_sched("decide_at_limit", 1'b0);
    n_chk++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL decide_at_limit_direct: pass=%b to=%b want 1/0",
               pass, timeout);
    end
    clear_sched();
    for (int h = 0; h < H; h++) begin
      add(h, 50, 27, 1);
      add(h, T, 26, 1);
    end
    run_sched("decide_past_limit", 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_sched();
    add(0, 6, 27, 1);
    add(0, 9, 26, 1);
    add(1, 7, 27, 1);
    add(1, 30, 26, 1);
    run_sched("restart_in_run", 1'b1);
    run_sched("rerun_same", 1'b1);
  endtask

  task automatic gen_random();
    int dcy;
    int k;
    int r;
    clear_sched();
    for (int h = 0; h < H; h++) begin
      k = $urandom_range(0, 9);
      dcy = (k == 0) ? 0 :
            (k == 1) ? $urandom_range(T - 3, T + 1) :
                       $urandom_range(1, 60);
      for (int c = 1; c <= L; c++) begin
        if (c == dcy) add(h, c, 26, 1);
        else if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 4);
          r = $urandom_range(0, 3);
          case (k)
            0: add(h, c, 0, int'($urandom));
            1: add(h, c, 3, $urandom_range(0, 255));
            2: add(h, c, 27, (r == 0) ? 0 :
                             (r == 3) ? int'($urandom) : 1);
            3: add(h, c, 26, (dcy == 0 || c < dcy) ?
                             ((r < 2) ? 0 : 2) :
                             $urandom_range(0, 2));
            default: add(h, c, $urandom_range(4, 25),
                         int'($urandom));
          endcase
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      gen_random();
      run_sched($sformatf("random%0d", i), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    we = '1;
    wa = {5'd27, 5'd27};
    wd = {32'd1, 32'd1};
    repeat (4) @(negedge clk);
    we = '0;
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({running, done, pass, fail, timeout, halt} !== '0 ||
        cycle_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: status=%b cnt=%0d want 0",
               {running, done, pass, fail, timeout, halt}, cycle_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (running !== 1'b0 || cycle_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun_idle: running=%b cnt=%0d want 0",
               running, cycle_cnt);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++;
    if (running1 !== 1'b1 || cycle_cnt1 !== 4'hf) begin
      n_fail++;
      $display("FAIL saturate: running=%b cnt=%0d want 1/15",
               running1, cycle_cnt1);
    end
    we1 = 1'b1;
    wa1 = 5'd27;
    wd1 = 32'd1;
    @(negedge clk);
    wa1 = 5'd26;
    @(negedge clk);
    we1 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (pass1 !== 1'b1 || done1 !== 1'b1 || cycle_cnt1 !== 4'hf) begin
      n_fail++;
      $display("FAIL saturate_pass: pass=%b done=%b cnt=%0d want 1/1/15",
               pass1, done1, cycle_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_pass_two();
    test_fail_hart1();
    test_fail_priority();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
